// File: rtl/hoplite_sw_if.sv
// Port bundle of a Hoplite torus switch: West/North links in, East/South
// links out, plus the PE injection handshake and the deflection counter.
interface hoplite_sw_if #(
    parameter int P_W   = 16,
    parameter int CNT_W = 16
);
    logic [P_W-1:0]   w_pkt;
    logic             w_vld;
    logic [P_W-1:0]   n_pkt;
    logic             n_vld;
    logic [P_W-1:0]   pe_pkt;
    logic             pe_vld;
    logic             sw_rdy;
    logic [P_W-1:0]   e_pkt;
    logic             e_vld;
    logic [P_W-1:0]   s_pkt;
    logic             s_vld;
    logic             pe_out_vld;
    logic [CNT_W-1:0] defl_cnt;

    // Master side feeds the router; it is what neighbours and the PE wrapper see.
    modport master (
        output w_pkt, w_vld, n_pkt, n_vld, pe_pkt, pe_vld,
        input  sw_rdy, e_pkt, e_vld, s_pkt, s_vld, pe_out_vld, defl_cnt
    );

    modport slave (
        input  w_pkt, w_vld, n_pkt, n_vld, pe_pkt, pe_vld,
        output sw_rdy, e_pkt, e_vld, s_pkt, s_vld, pe_out_vld, defl_cnt
    );
endinterface

// File: rtl/hoplite_sw.sv
// Bufferless Hoplite deflection router for a unidirectional 2D torus.
// X-then-Y routing, W > N > PE priority, losers deflected, registered links.
module hoplite_sw #(
    parameter int P_W   = 16,
    parameter int X_AW  = 2,
    parameter int Y_AW  = 2,
    parameter int X_POS = 0,
    parameter int Y_POS = 0,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    hoplite_sw_if.slave   sw
);

    localparam logic [X_AW-1:0] X_HERE = X_AW'(X_POS);
    localparam logic [Y_AW-1:0] Y_HERE = Y_AW'(Y_POS);

    logic [X_AW-1:0] w_dst_x, n_dst_x, pe_dst_x;
    logic [Y_AW-1:0] w_dst_y, n_dst_y, pe_dst_y;

    assign w_dst_x  = sw.w_pkt[P_W-1 -: X_AW];
    assign n_dst_x  = sw.n_pkt[P_W-1 -: X_AW];
    assign pe_dst_x = sw.pe_pkt[P_W-1 -: X_AW];
    assign w_dst_y  = sw.w_pkt[P_W-X_AW-1 -: Y_AW];
    assign n_dst_y  = sw.n_pkt[P_W-X_AW-1 -: Y_AW];
    assign pe_dst_y = sw.pe_pkt[P_W-X_AW-1 -: Y_AW];

    logic w_want_e, w_want_s;
    logic n_dx, n_defl, n_to_e, n_to_s;
    logic e_claim, s_claim;
    logic pe_dx, pe_to_e, pe_to_s;

    assign w_want_e = sw.w_vld & (w_dst_x != X_HERE);
    assign w_want_s = sw.w_vld & (w_dst_x == X_HERE);

    // North loses to West on whichever port it wants and takes the other one.
    assign n_dx   = (n_dst_x != X_HERE);
    assign n_defl = sw.n_vld & (n_dx ? w_want_e : w_want_s);
    assign n_to_e = sw.n_vld & (n_dx ^ n_defl);
    assign n_to_s = sw.n_vld & ~(n_dx ^ n_defl);

    assign e_claim = w_want_e | n_to_e;
    assign s_claim = w_want_s | n_to_s;

    assign pe_dx     = (pe_dst_x != X_HERE);
    assign sw.sw_rdy = sw.pe_vld & (pe_dx ? ~e_claim : ~s_claim);
    assign pe_to_e   = sw.sw_rdy & pe_dx;
    assign pe_to_s   = sw.sw_rdy & ~pe_dx;

    logic [P_W-1:0] e_nxt_pkt, s_nxt_pkt;
    logic           e_nxt_vld, s_nxt_vld, s_nxt_local;

    // Output muxes; claims are disjoint, so at most one source drives each port.
    always_comb begin
        e_nxt_vld   = e_claim | pe_to_e;
        e_nxt_pkt   = sw.pe_pkt;
        s_nxt_vld   = s_claim | pe_to_s;
        s_nxt_pkt   = sw.pe_pkt;
        s_nxt_local = pe_to_s & (pe_dst_y == Y_HERE);
        if (w_want_e) begin
            e_nxt_pkt = sw.w_pkt;
        end else if (n_to_e) begin
            e_nxt_pkt = sw.n_pkt;
        end
        if (w_want_s) begin
            s_nxt_pkt   = sw.w_pkt;
            s_nxt_local = (w_dst_y == Y_HERE);
        end else if (n_to_s) begin
            s_nxt_pkt   = sw.n_pkt;
            s_nxt_local = ~n_defl & (n_dst_y == Y_HERE);
        end
    end

    // Link registers; packet fields hold their last value while the link is idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw.e_pkt      <= '0;
            sw.e_vld      <= 1'b0;
            sw.s_pkt      <= '0;
            sw.s_vld      <= 1'b0;
            sw.pe_out_vld <= 1'b0;
        end else begin
            sw.e_vld      <= e_nxt_vld;
            sw.s_vld      <= s_nxt_vld & ~s_nxt_local;
            sw.pe_out_vld <= s_nxt_vld & s_nxt_local;
            if (e_nxt_vld) begin
                sw.e_pkt <= e_nxt_pkt;
            end
            if (s_nxt_vld) begin
                sw.s_pkt <= s_nxt_pkt;
            end
        end
    end

    // Only North can be deflected, so one increment per cycle at most.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw.defl_cnt <= '0;
        end else if (n_defl && (sw.defl_cnt != {CNT_W{1'b1}})) begin
            sw.defl_cnt <= sw.defl_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hoplite_sw.sv
// Bench for hoplite_sw: two nodes at different coordinates share one stimulus
// stream and are compared against a port-claiming reference model.
module tb_hoplite_sw;

    localparam int P_W = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hoplite_sw_if #(.P_W(P_W), .CNT_W(16)) bus0 ();
    hoplite_sw_if #(.P_W(P_W), .CNT_W(2))  bus1 ();

    hoplite_sw #(.P_W(P_W), .X_AW(2), .Y_AW(2), .X_POS(0), .Y_POS(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .sw(bus0)
    );
    hoplite_sw #(.P_W(P_W), .X_AW(2), .Y_AW(2), .X_POS(1), .Y_POS(2), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .sw(bus1)
    );

    assign bus1.w_pkt  = bus0.w_pkt;
    assign bus1.w_vld  = bus0.w_vld;
    assign bus1.n_pkt  = bus0.n_pkt;
    assign bus1.n_vld  = bus0.n_vld;
    assign bus1.pe_pkt = bus0.pe_pkt;
    assign bus1.pe_vld = bus0.pe_vld;

    int checks   = 0;
    int failures = 0;

    int px[2]   = '{0, 1};
    int py[2]   = '{0, 2};
    int cmax[2] = '{65535, 3};

    logic [P_W-1:0] m_e_pkt[2], m_s_pkt[2], n_e_pkt[2], n_s_pkt[2];
    bit             m_e_vld[2], m_s_vld[2], m_pe[2], n_e_vld[2], n_s_vld[2], n_pe[2];
    int             m_cnt[2], n_cnt[2];
    bit             m_rdy[2];
    logic           last_rdy0;

    function automatic logic [P_W-1:0] mk(input int x, input int y, input int pl);
        return {x[1:0], y[1:0], pl[11:0]};
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_e_pkt[k] = '0; m_s_pkt[k] = '0;
            m_e_vld[k] = 0;  m_s_vld[k] = 0;  m_pe[k] = 0;  m_cnt[k] = 0;
        end
    endtask

    // Sources claim ports in priority order; a taken port pushes N to the other one.
    task automatic model_eval(input int k);
        logic [P_W-1:0] pk[3];
        bit             vd[3];
        bit             taken[2];
        logic [P_W-1:0] op[2];
        bit             loc[2];
        bit             defl;
        int             want, port;
        pk = '{bus0.w_pkt, bus0.n_pkt, bus0.pe_pkt};
        vd = '{bus0.w_vld, bus0.n_vld, bus0.pe_vld};
        taken = '{0, 0}; loc = '{0, 0}; op[0] = '0; op[1] = '0;
        defl = 0;
        m_rdy[k] = 0;
        for (int src = 0; src < 3; src++) begin
            if (vd[src]) begin
                want = (int'(pk[src][15:14]) != px[k]) ? 0 : 1;
                port = want;
                if (taken[want] && src != 2) begin
                    port = 1 - want;
                    defl = 1;
                end
                if (!taken[port]) begin
                    if (src == 2) m_rdy[k] = 1;
                    taken[port] = 1;
                    op[port]    = pk[src];
                    loc[port]   = (port == 1) && (port == want) &&
                                  (int'(pk[src][13:12]) == py[k]);
                end
            end
        end
        n_e_vld[k] = taken[0];
        n_e_pkt[k] = taken[0] ? op[0] : m_e_pkt[k];
        n_s_pkt[k] = taken[1] ? op[1] : m_s_pkt[k];
        n_pe[k]    = taken[1] && loc[1];
        n_s_vld[k] = taken[1] && !loc[1];
        n_cnt[k]   = (defl && m_cnt[k] < cmax[k]) ? m_cnt[k] + 1 : m_cnt[k];
    endtask

    task automatic check_all();
        check_output("n0_e_vld", 32'(bus0.e_vld), 32'(m_e_vld[0]));
        check_output("n0_e_pkt", 32'(bus0.e_pkt), 32'(m_e_pkt[0]));
        check_output("n0_s_vld", 32'(bus0.s_vld), 32'(m_s_vld[0]));
        check_output("n0_s_pkt", 32'(bus0.s_pkt), 32'(m_s_pkt[0]));
        check_output("n0_pe_out", 32'(bus0.pe_out_vld), 32'(m_pe[0]));
        check_output("n0_defl", 32'(bus0.defl_cnt), 32'(m_cnt[0]));
        check_output("n1_e_vld", 32'(bus1.e_vld), 32'(m_e_vld[1]));
        check_output("n1_e_pkt", 32'(bus1.e_pkt), 32'(m_e_pkt[1]));
        check_output("n1_s_vld", 32'(bus1.s_vld), 32'(m_s_vld[1]));
        check_output("n1_s_pkt", 32'(bus1.s_pkt), 32'(m_s_pkt[1]));
        check_output("n1_pe_out", 32'(bus1.pe_out_vld), 32'(m_pe[1]));
        check_output("n1_defl", 32'(bus1.defl_cnt), 32'(m_cnt[1]));
    endtask

    // One cycle: drive inputs, check sw_rdy, clock, check registered outputs.
    task automatic apply_stimulus(input logic [P_W-1:0] wp, input bit wv,
                                  input logic [P_W-1:0] np, input bit nv,
                                  input logic [P_W-1:0] pp, input bit pv);
        bus0.w_pkt = wp; bus0.w_vld = wv;
        bus0.n_pkt = np; bus0.n_vld = nv;
        bus0.pe_pkt = pp; bus0.pe_vld = pv;
        #1;
        model_eval(0);
        model_eval(1);
        last_rdy0 = bus0.sw_rdy;
        check_output("n0_sw_rdy", 32'(bus0.sw_rdy), 32'(m_rdy[0]));
        check_output("n1_sw_rdy", 32'(bus1.sw_rdy), 32'(m_rdy[1]));
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            m_e_pkt[k] = n_e_pkt[k]; m_s_pkt[k] = n_s_pkt[k];
            m_e_vld[k] = n_e_vld[k]; m_s_vld[k] = n_s_vld[k];
            m_pe[k]    = n_pe[k];    m_cnt[k]   = n_cnt[k];
        end
        check_all();
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        #1;
        model_reset();
        check_output("rst_e_vld", 32'(bus0.e_vld | bus1.e_vld), 32'd0);
        check_output("rst_s_vld", 32'(bus0.s_vld | bus1.s_vld), 32'd0);
        check_output("rst_pe_out", 32'(bus0.pe_out_vld | bus1.pe_out_vld), 32'd0);
        check_output("rst_defl0", 32'(bus0.defl_cnt), 32'd0);
        check_output("rst_defl1", 32'(bus1.defl_cnt), 32'd0);
        check_output("rst_pkts", 32'(bus0.e_pkt | bus0.s_pkt), 32'd0);
        rst = 1'b0;
        #1;
    endtask

    logic [P_W-1:0] wp, np, pp;
    int sat_exp[4] = '{1, 2, 3, 3};

    initial begin
        rst = 1'b1;
        bus0.w_pkt = '0; bus0.w_vld = 1'b0;
        bus0.n_pkt = '0; bus0.n_vld = 1'b0;
        bus0.pe_pkt = '0; bus0.pe_vld = 1'b0;
        model_reset();
        #2;
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // West straight through East.
        wp = mk(2, 1, 12'hABC);
        apply_stimulus(wp, 1, '0, 0, '0, 0);
        check_output("t1_e_vld", 32'(bus0.e_vld), 32'd1);
        check_output("t1_e_pkt", 32'(bus0.e_pkt), 32'(wp));
        check_output("t1_s_vld", 32'(bus0.s_vld), 32'd0);
        check_output("t1_defl", 32'(bus0.defl_cnt), 32'd0);

        // W and N both want South: N deflected East.
        wp = mk(0, 3, 12'h123);
        np = mk(0, 2, 12'h456);
        apply_stimulus(wp, 1, np, 1, '0, 0);
        check_output("t2_s_pkt", 32'(bus0.s_pkt), 32'(wp));
        check_output("t2_s_vld", 32'(bus0.s_vld), 32'd1);
        check_output("t2_e_pkt", 32'(bus0.e_pkt), 32'(np));
        check_output("t2_e_vld", 32'(bus0.e_vld), 32'd1);
        check_output("t2_defl", 32'(bus0.defl_cnt), 32'd1);

        // North packet for this node is delivered to the PE.
        np = mk(0, 0, 12'h789);
        apply_stimulus('0, 0, np, 1, '0, 0);
        check_output("t3_pe_out", 32'(bus0.pe_out_vld), 32'd1);
        check_output("t3_s_vld", 32'(bus0.s_vld), 32'd0);
        check_output("t3_s_pkt", 32'(bus0.s_pkt), 32'(np));

        // PE blocked by West on East, then accepted once West goes idle.
        wp = mk(3, 0, 12'h011);
        pp = mk(1, 0, 12'h022);
        apply_stimulus(wp, 1, '0, 0, pp, 1);
        check_output("t4_rdy_blk", 32'(last_rdy0), 32'd0);
        check_output("t4_e_pkt", 32'(bus0.e_pkt), 32'(wp));
        apply_stimulus('0, 0, '0, 0, pp, 1);
        check_output("t4_rdy_ok", 32'(last_rdy0), 32'd1);
        check_output("t4_e_pkt_pe", 32'(bus0.e_pkt), 32'(pp));

        // Self-addressed injection with South free.
        pp = mk(0, 0, 12'h0F0);
        apply_stimulus('0, 0, '0, 0, pp, 1);
        check_output("t5_self_pe", 32'(bus0.pe_out_vld), 32'd1);
        check_output("t5_self_s", 32'(bus0.s_vld), 32'd0);

        // Saturation of the 2-bit counter on node 1.
        reset_pulse();
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(mk(0, 1, i), 1, mk(0, 2, i + 8), 1, '0, 0);
            check_output($sformatf("sat_n1_%0d", i), 32'(bus1.defl_cnt), 32'(sat_exp[i]));
            check_output($sformatf("sat_n0_%0d", i), 32'(bus0.defl_cnt), 32'(i + 1));
        end

        // Asynchronous reset mid-traffic, then 1-cycle latency after release.
        apply_stimulus(mk(2, 2, 12'h333), 1, mk(0, 1, 12'h444), 1, '0, 0);
        reset_pulse();
        wp = mk(3, 3, 12'h555);
        apply_stimulus(wp, 1, '0, 0, '0, 0);
        check_output("rst_rel_e_vld", 32'(bus0.e_vld), 32'd1);
        check_output("rst_rel_e_pkt", 32'(bus0.e_pkt), 32'(wp));

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            apply_stimulus(P_W'($urandom), ($urandom_range(0, 9) < 7),
                           P_W'($urandom), ($urandom_range(0, 9) < 7),
                           P_W'($urandom), ($urandom_range(0, 9) < 6));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
